// File: rtl/heartbeat_source.sv
// heartbeat_source: watchdog-link transmitter; heartbeats while alive, starves on inactivity, clears after a trip.
// Define HB_FAULT_INJECT_EN to add inject_drop, which suppresses heartbeats so the watchdog can be tripped.
module heartbeat_source #(
    parameter int CLK_FREQ    = 1,
    parameter int PERIOD_SEC  = 2,
    parameter int ALIVE_SEC   = 4,
    parameter int RECOVER_SEC = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        alive,
    input  logic        wd_triggered,
`ifdef HB_FAULT_INJECT_EN
    input  logic        inject_drop,
`endif
    output logic        heartbeat,
    output logic        force_reset,
    output logic [1:0]  state,
    output logic [15:0] hb_count
);
    localparam int PERIOD_CYCLES  = CLK_FREQ * PERIOD_SEC;
    localparam int ALIVE_CYCLES   = CLK_FREQ * ALIVE_SEC;
    localparam int RECOVER_CYCLES = CLK_FREQ * RECOVER_SEC;
    localparam int PW = PERIOD_CYCLES < 2 ? 1 : $clog2(PERIOD_CYCLES + 1);
    localparam int AW = ALIVE_CYCLES < 1 ? 1 : $clog2(ALIVE_CYCLES + 1);
    localparam int RW = RECOVER_CYCLES < 1 ? 1 : $clog2(RECOVER_CYCLES + 1);
    localparam logic [PW-1:0] P_LAST = PW'(PERIOD_CYCLES - 1);
    localparam logic [AW-1:0] A_LAST = AW'(ALIVE_CYCLES - 1);
    localparam logic [RW-1:0] R_MAX  = RW'(RECOVER_CYCLES);

    if (PERIOD_CYCLES < 2) begin : g_bad_period
        $error("heartbeat_source: PERIOD_CYCLES must be >= 2");
    end
    if (ALIVE_CYCLES < 1) begin : g_bad_alive
        $error("heartbeat_source: ALIVE_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_STARVED = 2'd2,
        S_RECOVER = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] period_cnt_q, period_cnt_d;
    logic [AW-1:0] alive_cnt_q, alive_cnt_d;
    logic [RW-1:0] recover_cnt_q, recover_cnt_d;
    logic          alive_latch_q, alive_latch_d;
    logic [1:0]    blank_cnt_q, blank_cnt_d;
    logic          heartbeat_q, heartbeat_d;
    logic          force_reset_q, force_reset_d;
    logic [15:0]   hb_count_q, hb_count_d;
    logic          hb_fire;
    logic          drop;

`ifdef HB_FAULT_INJECT_EN
    assign drop = inject_drop;
`else
    assign drop = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        period_cnt_d  = period_cnt_q;
        alive_cnt_d   = alive_cnt_q;
        recover_cnt_d = recover_cnt_q;
        alive_latch_d = alive_latch_q;
        blank_cnt_d   = blank_cnt_q != 2'd0 ? blank_cnt_q - 2'd1 : 2'd0;
        force_reset_d = 1'b0;
        hb_fire       = 1'b0;
        if (!enable) begin
            state_d       = S_IDLE;
            period_cnt_d  = '0;
            alive_cnt_d   = '0;
            recover_cnt_d = '0;
            alive_latch_d = 1'b0;
            blank_cnt_d   = 2'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d      = S_RUN;
                    period_cnt_d = '0;
                    alive_cnt_d  = '0;
                end
                S_RUN: begin
                    if (wd_triggered && blank_cnt_q == 2'd0) begin
                        state_d       = S_RECOVER;
                        recover_cnt_d = '0;
                        alive_latch_d = 1'b0;
                    end else if (!alive && alive_cnt_q == A_LAST) begin
                        state_d      = S_STARVED;
                        period_cnt_d = '0;
                        alive_cnt_d  = '0;
                    end else begin
                        hb_fire      = period_cnt_q == P_LAST;
                        period_cnt_d = hb_fire ? '0 : period_cnt_q + 1'b1;
                        alive_cnt_d  = alive ? '0 : alive_cnt_q + 1'b1;
                    end
                end
                S_STARVED: begin
                    if (wd_triggered) begin
                        state_d       = S_RECOVER;
                        recover_cnt_d = '0;
                        alive_latch_d = 1'b0;
                    end else if (alive) begin
                        state_d      = S_RUN;
                        hb_fire      = 1'b1;
                        period_cnt_d = '0;
                        alive_cnt_d  = '0;
                    end
                end
                S_RECOVER: begin
                    // blank_cnt hides the trip flag while the watchdog's registered clear settles
                    if (recover_cnt_q >= R_MAX && (alive_latch_q || alive)) begin
                        state_d       = S_RUN;
                        force_reset_d = 1'b1;
                        period_cnt_d  = '0;
                        alive_cnt_d   = '0;
                        blank_cnt_d   = 2'd2;
                    end else begin
                        recover_cnt_d = recover_cnt_q == R_MAX ? recover_cnt_q : recover_cnt_q + 1'b1;
                        alive_latch_d = alive_latch_q | alive;
                    end
                end
            endcase
        end
        heartbeat_d = hb_fire & ~drop;
        hb_count_d  = !enable ? 16'd0 :
                      (heartbeat_d && hb_count_q != 16'hFFFF) ? hb_count_q + 16'd1 : hb_count_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            period_cnt_q  <= '0;
            alive_cnt_q   <= '0;
            recover_cnt_q <= '0;
            alive_latch_q <= 1'b0;
            blank_cnt_q   <= 2'd0;
            heartbeat_q   <= 1'b0;
            force_reset_q <= 1'b0;
            hb_count_q    <= 16'd0;
        end else begin
            state_q       <= state_d;
            period_cnt_q  <= period_cnt_d;
            alive_cnt_q   <= alive_cnt_d;
            recover_cnt_q <= recover_cnt_d;
            alive_latch_q <= alive_latch_d;
            blank_cnt_q   <= blank_cnt_d;
            heartbeat_q   <= heartbeat_d;
            force_reset_q <= force_reset_d;
            hb_count_q    <= hb_count_d;
        end
    end

    assign heartbeat   = heartbeat_q;
    assign force_reset = force_reset_q;
    assign state       = state_q;
    assign hb_count    = hb_count_q;
endmodule

// File: tb/tb_heartbeat_source.sv
// tb_heartbeat_source: directed stimulus against a timestamp-based model of the heartbeat link.
module tb_heartbeat_source;
    localparam int P = 2;
    localparam int A = 4;
    localparam int R = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic alive = 1'b0;
    logic wd_triggered = 1'b0;
`ifdef HB_FAULT_INJECT_EN
    logic inject_drop = 1'b0;
`endif
    logic        heartbeat, force_reset;
    logic [1:0]  state;
    logic [15:0] hb_count;

    int n_cmp = 0;
    int n_bad = 0;

    heartbeat_source dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .alive(alive),
        .wd_triggered(wd_triggered),
`ifdef HB_FAULT_INJECT_EN
        .inject_drop(inject_drop),
`endif
        .heartbeat(heartbeat),
        .force_reset(force_reset),
        .state(state),
        .hb_count(hb_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input int k = 1);
        repeat (k) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Model: edge index n plus timestamps of run entry, last activity, recover entry and last clear.
    int n = 0, m_state = 0, run_start = 0, last_act = 0, rec_start = 0, fr_edge = -100, m_cnt = 0;
    bit seen = 0, m_hb = 0, m_fr = 0, drop = 0;

    always @(posedge clk or posedge rst) begin
`ifdef HB_FAULT_INJECT_EN
        drop = inject_drop;
`else
        drop = 1'b0;
`endif
        m_hb = 0;
        m_fr = 0;
        if (rst) begin
            n = 0; m_state = 0; m_cnt = 0; fr_edge = -100;
        end else begin
            n++;
            if (!enable) begin
                m_state = 0; m_cnt = 0; fr_edge = -100;
            end else if (m_state == 0) begin
                m_state = 1; run_start = n; last_act = n;
            end else if (wd_triggered && (m_state == 2 || (m_state == 1 && n - fr_edge > 2))) begin
                m_state = 3; rec_start = n; seen = 0;
            end else if (m_state == 1 && !alive && n - last_act == A) begin
                m_state = 2;
            end else if (m_state == 1) begin
                if (alive) last_act = n;
                if ((n - run_start) % P == 0) begin
                    m_hb = !drop;
                    if (!drop && m_cnt < 65535) m_cnt++;
                end
            end else if (m_state == 2 && alive) begin
                m_state = 1; run_start = n; last_act = n;
                m_hb = !drop;
                if (!drop && m_cnt < 65535) m_cnt++;
            end else if (m_state == 3) begin
                if (n - rec_start > R && (seen || alive)) begin
                    m_fr = 1; m_state = 1; run_start = n; last_act = n; fr_edge = n;
                end else begin
                    seen = seen | alive;
                end
            end
        end
    end

    logic hb_prev = 1'b0;
    always @(negedge clk) begin
        chk("heartbeat", heartbeat, m_hb);
        chk("force_reset", force_reset, m_fr);
        chk("state", state, m_state);
        chk("hb_count", hb_count, m_cnt);
        chk("hb_fr_overlap", heartbeat & force_reset, 0);
        chk("hb_back_to_back", heartbeat & hb_prev, 0);
        hb_prev = heartbeat;
    end

    initial begin
        int hb_seen;
        tick(2);
        chk("rst_state", state, 0);
        chk("rst_hb", heartbeat, 0);
        chk("rst_fr", force_reset, 0);
        chk("rst_cnt", hb_count, 0);
        rst = 1'b0;
        tick();
        // enable with alive every other cycle: heartbeats at k+2, k+4, k+6
        enable = 1'b1; alive = 1'b1;
        tick();
        chk("en_state_run", state, 1);
        for (int j = 1; j <= 6; j++) begin
            alive = (j % 2 == 0);
            tick();
            chk("en_hb_pattern", heartbeat, int'(j % 2 == 0));
        end
        chk("en_cnt3", hb_count, 3);
        alive = 1'b0;
        tick();
        // disable on the edge where a heartbeat is due
        enable = 1'b0;
        tick();
        chk("dis_hb", heartbeat, 0);
        chk("dis_state", state, 0);
        chk("dis_cnt", hb_count, 0);
        // starve: one heartbeat, then STARVED at k+4
        enable = 1'b1;
        tick();
        chk("stv_run", state, 1);
        tick(2);
        chk("stv_hb_k2", heartbeat, 1);
        tick();
        chk("stv_state_k3", state, 1);
        tick();
        chk("stv_state_k4", state, 2);
        chk("stv_hb_k4", heartbeat, 0);
        hb_seen = 0;
        for (int j = 0; j < 10; j++) begin
            tick();
            hb_seen += int'(heartbeat);
        end
        chk("stv_no_hb", hb_seen, 0);
        chk("stv_still", state, 2);
        // resume from STARVED
        alive = 1'b1;
        tick();
        chk("res_state", state, 1);
        chk("res_hb_s", heartbeat, 1);
        alive = 1'b0;
        tick();
        chk("res_hb_s1", heartbeat, 0);
        tick();
        chk("res_hb_s2", heartbeat, 1);
        chk("res_cnt", hb_count, 3);
        tick(2);
        chk("res_restarve", state, 2);
        // recovery from STARVED with alive held
        wd_triggered = 1'b1; alive = 1'b1;
        tick();
        chk("rec_state_t", state, 3);
        chk("rec_hb_t", heartbeat, 0);
        tick();
        chk("rec_state_t1", state, 3);
        chk("rec_fr_t1", force_reset, 0);
        tick();
        chk("rec_fr_t2", force_reset, 1);
        chk("rec_state_t2", state, 1);
        tick();
        chk("rec_blank_t3", state, 1);
        chk("rec_fr_t3", force_reset, 0);
        wd_triggered = 1'b0;
        tick();
        chk("rec_hb_t4", heartbeat, 1);
        tick();
        // trip from RUN on a heartbeat-due edge, alive only after holdoff
        wd_triggered = 1'b1;
        tick();
        chk("run_trip_state", state, 3);
        chk("run_trip_hb", heartbeat, 0);
        wd_triggered = 1'b0; alive = 1'b0;
        tick(3);
        chk("hold_state", state, 3);
        chk("hold_fr", force_reset, 0);
        alive = 1'b1;
        tick();
        chk("late_fr", force_reset, 1);
        chk("late_state", state, 1);
        tick(2);
        chk("pre_rst_hb", heartbeat, 1);
        // async reset drops outputs mid-cycle
        #1 rst = 1'b1;
        #1;
        chk("arst_hb", heartbeat, 0);
        chk("arst_state", state, 0);
        chk("arst_cnt", hb_count, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("arst_rerun", state, 1);
        tick(2);
        chk("arst_hb2", heartbeat, 1);
        chk("arst_cnt1", hb_count, 1);
`ifdef HB_FAULT_INJECT_EN
        inject_drop = 1'b1;
        hb_seen = 0;
        for (int j = 0; j < 6; j++) begin
            tick();
            hb_seen += int'(heartbeat);
        end
        chk("inj_no_hb", hb_seen, 0);
        chk("inj_cnt", hb_count, 1);
        chk("inj_state", state, 1);
        inject_drop = 1'b0;
        tick();
        chk("inj_rel_hb1", heartbeat, 0);
        tick();
        chk("inj_rel_hb2", heartbeat, 1);
        chk("inj_rel_cnt", hb_count, 2);
`endif
        tick(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/heartbeat_source.md
Name: heartbeat_source

Overview:
- Transmit end of the watchdog heartbeat link. Generates single-cycle heartbeat pulses at a fixed period while upstream control activity ("alive" pulses) is present.
- Deliberately starves the watchdog when activity stops.
- After a watchdog trip, issues a single force_reset pulse once activity returns and a holdoff has elapsed.
- Sits between the control/command path and the watchdog timer.

Parameters:
- CLK_FREQ, 1, clock cycles per second.
- PERIOD_SEC, 2, heartbeat period in seconds. PERIOD_CYCLES = CLK_FREQ*PERIOD_SEC; must be >= 2, otherwise elaboration error.
- ALIVE_SEC, 4, activity window in seconds. ALIVE_CYCLES = CLK_FREQ*ALIVE_SEC; must be >= 1.
- RECOVER_SEC, 1, minimum holdoff in RECOVER before force_reset. RECOVER_CYCLES = CLK_FREQ*RECOVER_SEC.

Ports:
- clk, in, 1: single clock; all logic on rising edge.
- rst, in, 1: reset, asynchronous and active-high.
- enable, in, 1: run enable; low forces IDLE.
- alive, in, 1: activity pulse from the command path.
- wd_triggered, in, 1: triggered output of the watchdog.
- heartbeat, out, 1: registered one-cycle heartbeat pulse.
- force_reset, out, 1: registered one-cycle watchdog clear pulse.
- state, out, 2: 0 IDLE, 1 RUN, 2 STARVED, 3 RECOVER.
- hb_count, out, 16: heartbeats since enable; saturates at 65535.

Behaviour:
- Reset: state=IDLE; heartbeat=0, force_reset=0, hb_count=0; all internal counters 0.
- Priority at every edge: rst > !enable > wd_triggered (when not blanked) > alive > timers.
- heartbeat and force_reset are registered, high for exactly one cycle, and never high together. heartbeat is never high in two consecutive cycles.
- !enable, any state: next state IDLE; outputs 0; hb_count and counters cleared.
- IDLE with enable=1: next state RUN; period_cnt=0, alive_cnt=0.
- RUN, period timer:
  - period_cnt increments each cycle.
  - At an edge where period_cnt==PERIOD_CYCLES-1: heartbeat<=1, period_cnt<=0, hb_count++ (saturating).
  - First heartbeat therefore appears PERIOD_CYCLES cycles after entering RUN.
- RUN, activity timer:
  - alive=1 clears alive_cnt; otherwise alive_cnt increments.
  - At an edge where alive_cnt==ALIVE_CYCLES-1 and alive=0: next state STARVED.
  - No heartbeat on that edge, even if the period expires simultaneously.
- RUN, alive coinciding with period expiry: heartbeat still emitted and alive_cnt cleared.
- STARVED:
  - No heartbeats.
  - alive=1: next state RUN with heartbeat<=1 on the same edge (immediate resume); period_cnt=0, alive_cnt=0.
  - wd_triggered=1: next state RECOVER (takes precedence over a simultaneous alive).
- RUN with wd_triggered=1 (not blanked): next state RECOVER, no heartbeat on that edge.
- RECOVER:
  - On entry: recover_cnt=0, alive_latch=0.
  - recover_cnt increments, saturating at RECOVER_CYCLES.
  - alive sets alive_latch.
  - At an edge where recover_cnt>=RECOVER_CYCLES and (alive_latch or alive): force_reset<=1, next state RUN; period_cnt=0, alive_cnt=0; blank_cnt<=2.
- Blanking: while blank_cnt!=0, wd_triggered is ignored in RUN, covering the watchdog's registered clear latency. blank_cnt decrements each cycle.
- Async rst mid-operation: outputs drop immediately. Any pulse in flight is lost.

Optional Feature:
- Macro: HB_FAULT_INJECT_EN.
- Defined: adds input inject_drop (1 bit). While inject_drop=1:
  - heartbeat output is forced 0 and hb_count does not increment.
  - Period, alive and state logic run unchanged.
  - Used to trip the watchdog on the bench without stopping activity.
- Undefined: port absent; no suppression logic.

Test Plan (default parameters):
- Reset and enable: rst=1 then 0, enable=1 at edge k, alive every 2 cycles -> state=RUN at k; heartbeat=1 at k+2, k+4, k+6; hb_count=3 after k+6.
- Starve: enable at k, no alive -> single heartbeat at k+2; state=STARVED at k+4; heartbeat stays 0 for at least 10 cycles.
- Resume from STARVED: alive at edge s -> state=RUN and heartbeat=1 at s; next heartbeat at s+2.
- Recovery:
  - In STARVED, wd_triggered=1 at edge t -> state=RECOVER at t.
  - With alive held high from t, force_reset=1 exactly at t+2 and state=RUN.
  - wd_triggered held until t+3 causes no re-entry to RECOVER.
- Disable mid-run: enable=0 on the edge where a heartbeat is due -> heartbeat=0, state=IDLE, hb_count=0 next cycle.
- HB_FAULT_INJECT_EN: inject_drop=1 during RUN with alive present -> heartbeat and hb_count frozen, state stays RUN. Releasing inject_drop -> heartbeat resumes on the next period boundary.
